// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared 8-bit memory.
// Port 0 is the CPU controller, port 1 the loader/DMA; a bounded lock lets the owner keep the bus.
module mem_bus_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] rvalid,
  output logic [7:0] rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_r;
  logic       ptr_r;
  logic       lock_r;
  logic [3:0] lock_cnt_r;
  logic [2:0] lat_cnt_r;

  logic       other_s;
  logic       win_s;
  logic       ext_s;
  logic       any_req_s;
  logic [7:0] sel_addr_s;
  logic [7:0] sel_wdata_s;
  logic       sel_we_s;
  logic       sel_lock_s;

  // Pick the winner for the next arbitration point and mux its request fields.
  always_comb begin
    other_s   = ~owner;
    any_req_s = |req;
    win_s     = 1'b0;
    ext_s     = 1'b0;
    if (lock_r && req[owner]) begin
      // An exhausted lock yields to a waiting peer; otherwise the owner keeps the bus.
      if ((lock_cnt_r == 4'(MAX_LOCK)) && req[other_s]) begin
        win_s = other_s;
        ext_s = 1'b0;
      end else begin
        win_s = owner;
        ext_s = 1'b1;
      end
    end else if (req[ptr_r]) begin
      win_s = ptr_r;
    end else begin
      win_s = ~ptr_r;
    end
    sel_addr_s  = win_s ? addr1  : addr0;
    sel_wdata_s = win_s ? wdata1 : wdata0;
    sel_we_s    = we[win_s];
    sel_lock_s  = lock[win_s];
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      ptr_r      <= 1'b0;
      lock_r     <= 1'b0;
      lock_cnt_r <= 4'd0;
      lat_cnt_r  <= 3'd0;
      gnt        <= 2'b00;
      rvalid     <= 2'b00;
      rdata      <= 8'h00;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      gnt    <= 2'b00;
      rvalid <= 2'b00;
      mem_en <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (any_req_s) begin
            state_r   <= ACCESS;
            busy      <= 1'b1;
            gnt       <= win_s ? 2'b10 : 2'b01;
            mem_en    <= 1'b1;
            mem_we    <= sel_we_s;
            mem_addr  <= sel_addr_s;
            mem_wdata <= sel_wdata_s;
            owner     <= win_s;
            lock_r    <= sel_lock_s;
            if (ext_s) begin
              if (lock_cnt_r != 4'(MAX_LOCK)) begin
                lock_cnt_r <= lock_cnt_r + 4'd1;
              end else begin
                lock_cnt_r <= lock_cnt_r;
              end
            end else begin
              lock_cnt_r <= 4'd0;
              ptr_r      <= ~win_s;
            end
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_we) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r   <= WAIT;
            busy      <= 1'b1;
            lat_cnt_r <= 3'd1;
          end
        end
        WAIT: begin
          busy <= 1'b1;
          if (lat_cnt_r == 3'(MEM_LAT)) begin
            state_r <= DONE;
            rdata   <= mem_rdata;
            rvalid  <= owner ? 2'b10 : 2'b01;
          end else begin
            state_r   <= WAIT;
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected grants/read returns,
// a negedge monitor pops and compares them whenever the DUT pulses gnt or rvalid.
module tb_mem_bus_arbiter;
  localparam int LAT   = 3;
  localparam int MLOCK = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] req, lock, we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_en, mem_we, busy, owner;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct { int cyc; int port; logic wr; logic [7:0] addr; logic [7:0] wdata; } gexp_t;
  typedef struct { int cyc; int port; logic [7:0] data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  mem_bus_arbiter #(.MEM_LAT(LAT), .MAX_LOCK(MLOCK)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: writes land in wmem; reads return addr^B5 only exactly LAT cycles after mem_en.
  logic [7:0] wmem [256];
  int         age = 1000;
  logic [7:0] rd_addr = 8'h00;
  always @(posedge clk) begin
    if (mem_en && mem_we) wmem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) begin
      rd_addr <= mem_addr;
      age     <= 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end
  assign mem_rdata = (age == LAT) ? (rd_addr ^ 8'hB5) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every grant / read-valid pulse.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    chk("mem_en_matches_gnt", 32'(mem_en), 32'(|gnt));
    if (gnt != 2'b00) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        g = gq.pop_front();
        chk("gnt_port", 32'(gnt), (g.port == 1) ? 32'd2 : 32'd1);
        chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
        chk("mem_we", 32'(mem_we), 32'(g.wr));
        chk("mem_addr", 32'(mem_addr), 32'(g.addr));
        if (g.wr) chk("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
      end
    end
    if (rvalid != 2'b00) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 32'(rvalid), 32'd0);
      end else begin
        r = rq.pop_front();
        chk("rvalid_port", 32'(rvalid), (r.port == 1) ? 32'd2 : 32'd1);
        chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
        chk("rdata", 32'(rdata), 32'(r.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_gnt(input int p, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        seen    = 1'b1;
        req[p]  = 1'b0;
        lock[p] = 1'b0;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    bit ok = 1'b0;
    int at = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    chk(name, 32'(at), 32'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, r0, n0, n1;
    logic [7:0] a0 [3], d0 [3], a1 [3], d1 [3];
    logic [7:0] la [6], ld [6];
    a0 = '{8'h80, 8'h81, 8'h82}; d0 = '{8'h11, 8'h12, 8'h13};
    a1 = '{8'h90, 8'h91, 8'h92}; d1 = '{8'h21, 8'h22, 8'h23};
    la = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    ld = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    req = 2'b00; lock = 2'b00; we = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

    // Reset values
    #2 reset_n = 1'b0;
    #1 chk("reset_outputs", {gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Single port 0 read of 0x10 returning A5
    c0 = cyc;
    we[0] = 1'b0; addr0 = 8'h10; req[0] = 1'b1;
    gq.push_back('{c0 + 1, 0, 1'b0, 8'h10, 8'h00});
    rq.push_back('{c0 + 2 + LAT, 0, 8'hA5});
    wait_gnt(0, "t1_gnt_seen");
    wait_idle("t1_idle_cycle", c0 + 3 + LAT);
    chk("t1_rdata_hold", 32'(rdata), 32'hA5);

    // Port 1 arrives while a port 0 read is in WAIT: granted right after rvalid
    tick();
    c0 = cyc;
    we[0] = 1'b0; addr0 = 8'h20; req[0] = 1'b1;
    gq.push_back('{c0 + 1, 0, 1'b0, 8'h20, 8'h00});
    rq.push_back('{c0 + 2 + LAT, 0, 8'h95});
    wait_gnt(0, "t3_gnt0_seen");
    goto_cycle(c0 + 3);
    we[1] = 1'b1; addr1 = 8'h40; wdata1 = 8'h77; req[1] = 1'b1;
    gq.push_back('{c0 + 3 + LAT, 1, 1'b1, 8'h40, 8'h77});
    wait_gnt(1, "t3_gnt1_seen");
    wait_idle("t3_idle_cycle", c0 + 4 + LAT);

    // Both ports writing continuously, no lock: strict alternation starting at port 0
    tick();
    c0 = cyc;
    addr0 = a0[0]; wdata0 = d0[0]; addr1 = a1[0]; wdata1 = d1[0];
    we = 2'b11; lock = 2'b00; req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      gq.push_back('{c0 + 1 + 4 * k, 0, 1'b1, a0[k], d0[k]});
      gq.push_back('{c0 + 3 + 4 * k, 1, 1'b1, a1[k], d1[k]});
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < 60 && (n0 < 3 || n1 < 3); i++) begin
      @(negedge clk);
      if (gnt[0]) begin
        n0++;
        if (n0 == 3) req[0] = 1'b0;
        else begin addr0 = a0[n0]; wdata0 = d0[n0]; end
      end
      if (gnt[1]) begin
        n1++;
        if (n1 == 3) req[1] = 1'b0;
        else begin addr1 = a1[n1]; wdata1 = d1[n1]; end
      end
    end
    chk("t2_port0_grants", 32'(n0), 32'd3);
    chk("t2_port1_grants", 32'(n1), 32'd3);
    wait_idle("t2_idle_cycle", c0 + 12);
    for (int k = 0; k < 3; k++) begin
      chk("t2_mem_port0", 32'(wmem[a0[k]]), 32'(d0[k]));
      chk("t2_mem_port1", 32'(wmem[a1[k]]), 32'(d1[k]));
    end

    // Port 0 locked vs port 1: 1 + MAX_LOCK grants to port 0, then port 1, then port 0
    tick();
    c0 = cyc;
    addr0 = la[0]; wdata0 = ld[0]; addr1 = 8'hB0; wdata1 = 8'h66;
    we = 2'b11; lock = 2'b01; req = 2'b11;
    for (int k = 0; k < 5; k++) gq.push_back('{c0 + 1 + 2 * k, 0, 1'b1, la[k], ld[k]});
    gq.push_back('{c0 + 11, 1, 1'b1, 8'hB0, 8'h66});
    gq.push_back('{c0 + 13, 0, 1'b1, la[5], ld[5]});
    n0 = 0; n1 = 0;
    for (int i = 0; i < 60 && (n0 < 6 || n1 < 1); i++) begin
      @(negedge clk);
      if (gnt[0]) begin
        n0++;
        if (n0 == 6) begin req[0] = 1'b0; lock[0] = 1'b0; end
        else begin addr0 = la[n0]; wdata0 = ld[n0]; end
      end
      if (gnt[1]) begin
        n1++;
        req[1] = 1'b0;
      end
    end
    chk("t4_port0_grants", 32'(n0), 32'd6);
    chk("t4_port1_grants", 32'(n1), 32'd1);
    wait_idle("t4_idle_cycle", c0 + 14);
    chk("t4_mem_b0", 32'(wmem[8'hB0]), 32'h66);
    chk("t4_mem_a5", 32'(wmem[8'hA5]), 32'h55);

    // No requests for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", {28'd0, busy, mem_en, gnt}, 32'd0);
    end

    // Reset in the second WAIT cycle aborts the read; port 1 then granted in one cycle
    tick();
    c0 = cyc;
    we[0] = 1'b0; addr0 = 8'h10; req[0] = 1'b1;
    gq.push_back('{c0 + 1, 0, 1'b0, 8'h10, 8'h00});
    wait_gnt(0, "t5_gnt0_seen");
    goto_cycle(c0 + 3);
    reset_n = 1'b0;
    #1 chk("t5_reset_outputs", {gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner}, 32'd0);
    goto_cycle(c0 + 6);
    reset_n = 1'b1;
    r0 = cyc;
    we[1] = 1'b0; addr1 = 8'h10; req[1] = 1'b1;
    gq.push_back('{r0 + 1, 1, 1'b0, 8'h10, 8'h00});
    rq.push_back('{r0 + 2 + LAT, 1, 8'hA5});
    wait_gnt(1, "t5_gnt1_seen");
    wait_idle("t5_idle_cycle", r0 + 3 + LAT);

    repeat (3) tick();
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
